// File: rtl/spi_target_if.sv
// Bus bundle for the SPI target endpoint: serial link pins, RX FIFO
// valid/ready port, TX byte handshake and sticky status flags.
interface spi_target_if;
    logic        spi_cs;
    logic        spi_mosi;
    logic        spi_miso;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        rx_overflow;
    logic        frame_abort;
    logic        flag_clr;

    modport master (
        output spi_cs, spi_mosi, rx_ready, tx_data, tx_valid, flag_clr,
        input  spi_miso, rx_data, rx_valid, tx_ready, rx_overflow, frame_abort
    );

    modport slave (
        input  spi_cs, spi_mosi, rx_ready, tx_data, tx_valid, flag_clr,
        output spi_miso, rx_data, rx_valid, tx_ready, rx_overflow, frame_abort
    );
endinterface

// File: rtl/spi_target_endpoint.sv
// SPI target endpoint: 32-bit start-bit framed RX into a FIFO, 8-bit start-bit
// framed TX on miso. Optional RX->TX low-byte echo under SPI_TGT_ECHO_EN.
//
// state     | meaning
// RXS_IDLE  | waiting for start bit (cs=1, mosi=0)
// RXS_BITS  | shifting 32 data bits, MSB first
// TXS_IDLE  | tx_ready, miso idles high
// TXS_START | miso driven 0 (start bit)
// TXS_BITS  | miso driven with byte bits 7..0
// TXS_GAP   | miso held high for TX_GAP cycles
module spi_target_endpoint #(
    parameter int RX_DEPTH = 4,
    parameter int TX_GAP   = 2
) (
    input logic         clk,
    input logic         rst,
    spi_target_if.slave bus
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((TX_GAP > 0) ? TX_GAP - 1 : 0);

    localparam logic       RXS_IDLE  = 1'b0;
    localparam logic       RXS_BITS  = 1'b1;
    localparam logic [1:0] TXS_IDLE  = 2'd0;
    localparam logic [1:0] TXS_START = 2'd1;
    localparam logic [1:0] TXS_BITS  = 2'd2;
    localparam logic [1:0] TXS_GAP   = 2'd3;

    logic        rx_state;
    logic [4:0]  rx_cnt;
    logic [30:0] rx_shift;
    logic        rx_push;
    logic [31:0] rx_word;
    logic        abort_set;

    logic [31:0] mem [RX_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_pop;
    logic        fifo_wr;
    logic        ovf_set;

    logic [1:0]    tx_state;
    logic [7:0]    tx_byte;
    logic [2:0]    tx_bit;
    logic [GW-1:0] gap_cnt;
    logic          tx_idle_rdy;
    logic          tx_load;
    logic [7:0]    tx_load_byte;
    logic          miso;

    // ---------------- RX deserialiser ----------------
    assign rx_push   = (rx_state == RXS_BITS) && bus.spi_cs && (rx_cnt == 5'd0);
    assign abort_set = (rx_state == RXS_BITS) && !bus.spi_cs;
    assign rx_word   = {rx_shift, bus.spi_mosi};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RXS_IDLE;
            rx_cnt   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RXS_IDLE: begin
                    if (bus.spi_cs && !bus.spi_mosi) begin
                        rx_cnt   <= 5'd31;
                        rx_state <= RXS_BITS;
                    end
                end
                default: begin
                    if (!bus.spi_cs || rx_cnt == 5'd0) begin
                        rx_state <= RXS_IDLE;
                    end else begin
                        rx_shift <= {rx_shift[29:0], bus.spi_mosi};
                        rx_cnt   <= rx_cnt - 5'd1;
                    end
                end
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    // Extra pointer MSB distinguishes full from empty.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_pop   = !fifo_empty && bus.rx_ready;
    assign fifo_wr    = rx_push && (!fifo_full || fifo_pop);
    assign ovf_set    = rx_push && fifo_full && !fifo_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr)  wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr[AW-1:0]] <= rx_word;
    end

    assign bus.rx_valid = !fifo_empty;
    assign bus.rx_data  = fifo_empty ? 32'd0 : mem[rd_ptr[AW-1:0]];

    // Sticky flags; a set event beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rx_overflow <= 1'b0;
            bus.frame_abort <= 1'b0;
        end else begin
            if (ovf_set)           bus.rx_overflow <= 1'b1;
            else if (bus.flag_clr) bus.rx_overflow <= 1'b0;
            if (abort_set)         bus.frame_abort <= 1'b1;
            else if (bus.flag_clr) bus.frame_abort <= 1'b0;
        end
    end

    // ---------------- TX source select ----------------
`ifdef SPI_TGT_ECHO_EN
    logic       echo_pend;
    logic [7:0] echo_byte;
    logic       echo_take;

    assign echo_take    = (tx_state == TXS_IDLE) && echo_pend;
    assign tx_idle_rdy  = (tx_state == TXS_IDLE) && !echo_pend;
    assign tx_load      = echo_take || (tx_idle_rdy && bus.tx_valid);
    assign tx_load_byte = echo_take ? echo_byte : bus.tx_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_pend <= 1'b0;
            echo_byte <= '0;
        end else if (fifo_wr) begin
            echo_pend <= 1'b1;
            echo_byte <= rx_word[7:0];
        end else if (echo_take) begin
            echo_pend <= 1'b0;
        end
    end
`else
    assign tx_idle_rdy  = (tx_state == TXS_IDLE);
    assign tx_load      = tx_idle_rdy && bus.tx_valid;
    assign tx_load_byte = bus.tx_data;
`endif

    assign bus.tx_ready = tx_idle_rdy;

    // ---------------- TX serialiser ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TXS_IDLE;
            tx_byte  <= '0;
            tx_bit   <= '0;
            gap_cnt  <= '0;
        end else begin
            case (tx_state)
                TXS_IDLE: begin
                    if (tx_load) begin
                        tx_byte  <= tx_load_byte;
                        tx_state <= TXS_START;
                    end
                end
                TXS_START: begin
                    tx_bit   <= 3'd7;
                    tx_state <= TXS_BITS;
                end
                TXS_BITS: begin
                    if (tx_bit == 3'd0) begin
                        gap_cnt  <= GAP_LOAD;
                        tx_state <= (TX_GAP == 0) ? TXS_IDLE : TXS_GAP;
                    end else begin
                        tx_bit <= tx_bit - 3'd1;
                    end
                end
                default: begin
                    if (gap_cnt == '0) tx_state <= TXS_IDLE;
                    else               gap_cnt  <= gap_cnt - 1'b1;
                end
            endcase
        end
    end

    // Decoded straight from state so reset forces miso high without waiting for a clock.
    always_comb begin
        miso = 1'b1;
        case (tx_state)
            TXS_START: miso = 1'b0;
            TXS_BITS:  miso = tx_byte[tx_bit];
            default:   miso = 1'b1;
        endcase
    end

    assign bus.spi_miso = miso;
endmodule

// File: tb/tb_spi_target_endpoint.sv
// Self-checking bench for spi_target_endpoint: directed scenarios plus random
// traffic, compared each cycle against a queue-based behavioural model.
module tb_spi_target_endpoint;
    localparam int RX_DEPTH = 4;
    localparam int TX_GAP   = 2;

    logic clk = 1'b0;
    logic rst;
    spi_target_if bus ();

    spi_target_endpoint #(.RX_DEPTH(RX_DEPTH), .TX_GAP(TX_GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: FIFO contents as a queue, pending miso bit stream as a queue.
    logic [31:0] m_fifo [$];
    bit          m_txq [$];
    bit          m_rx_busy;
    int          m_nbits;
    logic [31:0] m_word;
    bit          m_ovf;
    bit          m_abort;
    bit          m_echo_pend;
    logic [7:0]  m_echo;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_fifo.delete();
        m_txq.delete();
        m_rx_busy   = 0;
        m_nbits     = 0;
        m_word      = '0;
        m_ovf       = 0;
        m_abort     = 0;
        m_echo_pend = 0;
        m_echo      = '0;
    endfunction

    function automatic void enqueue_byte(input logic [7:0] b);
        m_txq.push_back(1'b0);
        for (int i = 7; i >= 0; i--) m_txq.push_back(b[i]);
        for (int i = 0; i < TX_GAP; i++) m_txq.push_back(1'b1);
    endfunction

    task automatic compare_outputs();
        chk("miso", bus.spi_miso, (m_txq.size() != 0) ? m_txq[0] : 1'b1);
        chk("tx_ready", bus.tx_ready, (m_txq.size() == 0) && !m_echo_pend);
        chk("rx_valid", bus.rx_valid, m_fifo.size() != 0);
        if (m_fifo.size() != 0) chk("rx_data", bus.rx_data, m_fifo[0]);
        chk("rx_overflow", bus.rx_overflow, m_ovf);
        chk("frame_abort", bus.frame_abort, m_abort);
    endtask

    // Advance one clock with the currently driven inputs, update the model, then check.
    task automatic cycle();
        bit          pop, push, full, ovf_set, ab_set, tx_empty;
        logic [31:0] pw;
        pw     = '0;
        push   = 0;
        ab_set = 0;
        pop    = (m_fifo.size() != 0) && bus.rx_ready;
        if (!m_rx_busy) begin
            if (bus.spi_cs && !bus.spi_mosi) begin
                m_rx_busy = 1;
                m_nbits   = 0;
            end
        end else if (!bus.spi_cs) begin
            m_rx_busy = 0;
            ab_set    = 1;
        end else begin
            m_word = {m_word[30:0], bus.spi_mosi};
            m_nbits++;
            if (m_nbits == 32) begin
                push      = 1;
                pw        = m_word;
                m_rx_busy = 0;
            end
        end
        full    = (m_fifo.size() == RX_DEPTH);
        ovf_set = push && full && !pop;
        if (pop) void'(m_fifo.pop_front());
        if (push && !ovf_set) m_fifo.push_back(pw);
        if (ovf_set) m_ovf = 1;
        else if (bus.flag_clr) m_ovf = 0;
        if (ab_set) m_abort = 1;
        else if (bus.flag_clr) m_abort = 0;

        tx_empty = (m_txq.size() == 0);
        if (!tx_empty) void'(m_txq.pop_front());
`ifdef SPI_TGT_ECHO_EN
        if (tx_empty && m_echo_pend) begin
            enqueue_byte(m_echo);
            m_echo_pend = 0;
        end else if (tx_empty && bus.tx_valid) begin
            enqueue_byte(bus.tx_data);
        end
        if (push && !ovf_set) begin
            m_echo_pend = 1;
            m_echo      = pw[7:0];
        end
`else
        if (tx_empty && bus.tx_valid) enqueue_byte(bus.tx_data);
`endif
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic send_frame(input logic [31:0] w);
        bus.spi_cs   = 1'b1;
        bus.spi_mosi = 1'b0;
        cycle();
        for (int i = 31; i >= 0; i--) begin
            bus.spi_mosi = w[i];
            cycle();
        end
        bus.spi_mosi = 1'b1;
    endtask

    task automatic pop_one();
        bus.rx_ready = 1'b1;
        cycle();
        bus.rx_ready = 1'b0;
    endtask

    task automatic clear_flags();
        bus.flag_clr = 1'b1;
        cycle();
        bus.flag_clr = 1'b0;
    endtask

    initial begin
        logic [8:0]  exp9;
        logic [8:0]  got9;
        logic [31:0] w;

        bus.spi_cs   = 1'b0;
        bus.spi_mosi = 1'b1;
        bus.rx_ready = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.flag_clr = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_miso", bus.spi_miso, 1);
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_ovf", bus.rx_overflow, 0);
        chk("rst_abort", bus.frame_abort, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) cycle();

        // Single frame: valid exactly 33 cycles after the start bit.
        send_frame(32'hDEADBEEF);
        chk("deadbeef_valid", bus.rx_valid, 1);
        chk("deadbeef_data", bus.rx_data, 32'hDEADBEEF);
        pop_one();
        chk("deadbeef_drained", bus.rx_valid, 0);

        // Five zero-gap frames into a 4-deep FIFO.
        for (int i = 1; i <= 5; i++) send_frame(32'(i));
        chk("ovf_set", bus.rx_overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_pop_data", bus.rx_data, 32'(i));
            pop_one();
        end
        chk("ovf_empty", bus.rx_valid, 0);
        clear_flags();
        chk("ovf_cleared", bus.rx_overflow, 0);

        // Abort after 10 data bits, then a clean frame.
        bus.spi_cs   = 1'b1;
        bus.spi_mosi = 1'b0;
        cycle();
        for (int i = 0; i < 10; i++) begin
            bus.spi_mosi = 1'($urandom_range(0, 1));
            cycle();
        end
        bus.spi_cs = 1'b0;
        cycle();
        chk("abort_set", bus.frame_abort, 1);
        send_frame(32'h00000055);
        chk("abort_data", bus.rx_data, 32'h00000055);
        pop_one();
        chk("abort_only_one", bus.rx_valid, 0);
        clear_flags();
        bus.spi_cs = 1'b0;
        cycle();

        // TX 0xA5: start bit at t+1, bits at t+2..t+9, ready at t+10+TX_GAP.
        chk("a5_idle_miso", bus.spi_miso, 1);
        bus.tx_data  = 8'hA5;
        bus.tx_valid = 1'b1;
        cycle();
        bus.tx_valid = 1'b0;
        exp9 = 9'b0_1010_0101;
        for (int k = 1; k <= 12; k++) begin
            if (k <= 9) chk("a5_bit", bus.spi_miso, exp9[9-k]);
            else        chk("a5_gap_miso", bus.spi_miso, 1);
            chk("a5_ready", bus.tx_ready, (k == 10 + TX_GAP) ? 1'b1 : 1'b0);
            if (k < 12) cycle();
        end

        // Full duplex: RX frame and TX byte start together.
        w = 32'h12345678;
        bus.spi_cs   = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        cycle();
        bus.tx_valid = 1'b0;
        got9 = '0;
        got9[8] = bus.spi_miso;
        for (int n = 0; n < 32; n++) begin
            bus.spi_mosi = w[31-n];
            cycle();
            if (n < 8) got9[7-n] = bus.spi_miso;
        end
        bus.spi_mosi = 1'b1;
        chk("dup_tx", got9, {1'b0, 8'h3C});
        chk("dup_rx", bus.rx_data, 32'h12345678);
        pop_one();
        repeat (4) cycle();

`ifdef SPI_TGT_ECHO_EN
        // Echo goes ahead of a waiting tx_valid.
        send_frame(32'h000000C3);
        bus.tx_data  = 8'h11;
        bus.tx_valid = 1'b1;
        chk("echo_blocks_ready", bus.tx_ready, 0);
        cycle();
        got9 = '0;
        got9[8] = bus.spi_miso;
        for (int n = 0; n < 8; n++) begin
            cycle();
            got9[7-n] = bus.spi_miso;
        end
        chk("echo_byte", got9, {1'b0, 8'hC3});
        for (int n = 0; n < 20 && bus.tx_ready !== 1'b1; n++) cycle();
        chk("echo_then_tx_ready", bus.tx_ready, 1);
        cycle();
        bus.tx_valid = 1'b0;
        repeat (14) cycle();
        pop_one();
`endif

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            bus.spi_cs   = ($urandom_range(0, 49) != 0);
            bus.spi_mosi = 1'($urandom_range(0, 1));
            bus.rx_ready = ($urandom_range(0, 9) < 3);
            bus.tx_valid = ($urandom_range(0, 9) < 3);
            bus.tx_data  = 8'($urandom);
            bus.flag_clr = ($urandom_range(0, 31) == 0);
            cycle();
        end
        bus.tx_valid = 1'b0;
        bus.flag_clr = 1'b0;
        bus.rx_ready = 1'b0;

        // Asynchronous reset mid-TX with a zero byte on the wire.
        repeat (14) cycle();
        bus.spi_cs   = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = (bus.tx_ready === 1'b1);
        cycle();
        bus.tx_valid = 1'b0;
        bus.spi_mosi = 1'b1;
        repeat (4) cycle();
        rst = 1'b1;
        #2;
        chk("arst_miso", bus.spi_miso, 1);
        chk("arst_tx_ready", bus.tx_ready, 1);
        chk("arst_rx_valid", bus.rx_valid, 0);
        model_reset();
        rst = 1'b0;
        bus.spi_cs = 1'b0;
        cycle();
        send_frame(32'hCAFEF00D);
        chk("post_rst_frame", bus.rx_data, 32'hCAFEF00D);
        pop_one();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_target_endpoint.md
# spi_target_endpoint

SPI target-side endpoint for the single-clock SPI link driven by the CPU-side SPI peripheral controller. It deserialises 32-bit command frames arriving on `spi_mosi` under `spi_cs` into a small RX FIFO with a valid/ready interface. It also serialises 8-bit response bytes onto `spi_miso` using the controller's start-bit framing. The block sits in the peripheral device model or target logic, clocked by the same `clk` that the controller drives out as `spi_sclk`.

## Interface
- `RX_DEPTH`, default 4: RX FIFO entries, power of two, minimum 2.
- `TX_GAP`, default 2: idle-high `spi_miso` cycles enforced after each transmitted byte before `tx_ready` returns; 0 is allowed.
- `clk` in 1: clock, identical to the link `spi_sclk`; all sampling and driving occur on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `spi_cs` in 1: frame enable from the controller, active-high.
- `spi_mosi` in 1: serial command data.
- `spi_miso` out 1: serial response data; idles high.
- `rx_data` out 32: FIFO head word.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: pop the head when `rx_valid && rx_ready`.
- `tx_data` in 8: response byte.
- `tx_valid` in 1: response byte offered.
- `tx_ready` out 1: transmitter can accept a byte.
- `rx_overflow` out 1: sticky; a completed frame was dropped because the FIFO was full.
- `frame_abort` out 1: sticky; `spi_cs` fell mid-frame.
- `flag_clr` in 1: synchronous clear of both sticky flags.

## Operation
- **RX FSM:** RX_IDLE, RX_BITS.
  - RX_IDLE: `spi_cs=1 && spi_mosi=0` is the start bit; load bit counter 31 and go to RX_BITS. `spi_cs=1` with `spi_mosi=1` is ignored.
  - RX_BITS: each cycle, sample `spi_mosi` into the shift register, MSB (bit 31) first, and decrement the counter.
  - On the cycle the counter reaches 0, push `{shift[30:0], spi_mosi}` into the FIFO and return to RX_IDLE.
  - `spi_cs=0` in RX_BITS: discard the partial word, set `frame_abort`, go to RX_IDLE.
- **FIFO push/pop rules:**
  - Push while full with no pop in the same cycle: drop the word and set `rx_overflow`.
  - Push and pop in the same cycle: both take effect, including when full.
  - Pointers are log2(`RX_DEPTH`)+1 bits and wrap modulo 2×`RX_DEPTH`.
- **TX FSM:** TX_IDLE, TX_START, TX_BITS, TX_GAP.
  - TX_IDLE: `tx_ready=1`. `tx_valid` latches `tx_data` and moves to TX_START.
  - TX_START drives `spi_miso=0` for 1 cycle.
  - TX_BITS drives bits 7..0, one per cycle.
  - TX_GAP drives 1 for `TX_GAP` cycles, then returns to TX_IDLE. With `TX_GAP`=0, go straight to TX_IDLE.
- RX and TX are fully independent; full duplex is permitted.
- The link has no backpressure on miso. The controller holds each received byte until its CPU reads it, and the producer driving `tx_valid` owns that pacing.
- `flag_clr` coinciding with a set event: the set wins.

## Timing
- **Reset values:** `spi_miso=1`, `tx_ready=1`, `rx_valid=0`, `rx_data=0`, `rx_overflow=0`, `frame_abort=0`; FIFO empty; both FSMs idle.
- **RX latency:** start bit on mosi in cycle k gives data bits in cycles k+1..k+32. `rx_valid` is high in cycle k+33 when the FIFO was empty.
- The next start bit is accepted in the cycle immediately after bit 0 (zero-gap back-to-back frames).
- **TX timing:** handshake in cycle t gives the start bit in t+1, bit 7 in t+2, …, bit 0 in t+9, and `tx_ready` high again in t+10+`TX_GAP`.
- **`tx_ready` while busy:** low from t+1 until that point; `tx_valid` during that time is not consumed.
- **Reset mid-operation:** the partial RX word and the in-flight TX byte are lost, and `spi_miso` returns to 1 immediately (asynchronous).

## Configuration
- `SPI_TGT_ECHO_EN` defined:
  - Each word pushed into the FIFO also loads `rx[7:0]` into a one-deep echo register.
  - The TX FSM in TX_IDLE sends a pending echo ahead of `tx_valid`, and `tx_ready` is 0 in that cycle.
  - A new echo overwrites an unsent one.
- `SPI_TGT_ECHO_EN` undefined: no echo logic; TX is driven only by `tx_valid`.

## Test plan
- Start bit then 0xDEADBEEF MSB-first, `rx_ready=0` → `rx_valid=1` with `rx_data=0xDEADBEEF` exactly 33 cycles after the start bit.
- Five back-to-back frames 0x1..0x5 with `rx_ready=0`, `RX_DEPTH`=4 → `rx_overflow=1`; pops return 0x1..0x4 in order, then `rx_valid=0`.
- `spi_cs` drops after 10 data bits, then a full frame 0x00000055 → `frame_abort=1` and the FIFO holds only 0x00000055.
- `tx_data=0xA5` handshaken in cycle t → miso reads 1 before t+1, then 0,1,0,1,0,0,1,0,1 over cycles t+1..t+9. Miso returns to 1 and `tx_ready` rises at t+12 (`TX_GAP`=2).
- Simultaneous RX frame 0x12345678 and TX byte 0x3C → both complete with correct data and timing.
- With `SPI_TGT_ECHO_EN`, frame 0x000000C3 and `tx_valid` held with 0x11 → miso sends 0xC3 first, then 0x11.
